program_flow_unit: RTL
======================

# program_flow_unit

Parametrised program-flow unit that owns the program counter and the status register for the core. It executes NOP, JMP, JMPZ, JMPS, JMPZS, LSTAT, XSTAT, TRAP and RTT from a valid/ready instruction stream. It also handles ALU-raised traps through a trap-entry state machine with a saved return address and double-fault halt. It sits between instruction decode (upstream) and fetch / general-purpose register writeback (downstream).

## Interface
- ADDR_W, 20: program counter, relative offset and GP data width; must be ≥ 8.
- RESET_PC, 0: PC value after reset.
- TRAP_VECTOR, 'h00010: PC loaded on trap entry.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  decoder presents an instruction.
- instr_ready  out  1  unit accepts it. Combinational: (state==RUN) & ~alu_trap.
- opcode  in  4  0 NOP, 1 JMP, 2 JMPZ, 3 JMPS, 4 JMPZS, 5 LSTAT, 6 XSTAT, 7 TRAP, 8 RTT; 9–15 illegal.
- rel_addr  in  ADDR_W  two's-complement branch offset.
- src_reg  in  ADDR_W  GP operand for XSTAT.
- flag_we  in  1  ALU flag update strobe.
- flag_in  in  3  {C,S,Z} from ALU.
- alu_trap  in  1  ALU trap request, level-sampled.
- pc  out  ADDR_W  current PC.
- status  out  4  {T,C,S,Z}; T = trap mode.
- epc  out  ADDR_W  saved return PC.
- gp_wdata  out  ADDR_W  writeback data for LSTAT/XSTAT.
- gp_we  out  1  one-cycle writeback strobe.
- branch_taken  out  1  one-cycle pulse after a taken jump.
- halted  out  1  double fault; sticky until reset.

## Operation
- States: RUN, TRAP_ENTER, HALT.
- Reset values: state=RUN, pc=RESET_PC, status=0, epc=0, gp_wdata=0, gp_we=0, branch_taken=0, halted=0.
- An instruction is accepted on an edge where instr_valid & instr_ready. Only accepted instructions change state.
- PC arithmetic is modulo 2^ADDR_W and wraps silently.
  - Not taken: pc+1.
  - Taken: pc+rel_addr.
- Branch conditions use the registered status:
  - JMP: always taken.
  - JMPZ: taken if Z.
  - JMPS: taken if S.
  - JMPZS: taken if Z|S.
- LSTAT: gp_wdata={0,status}, gp_we=1. PC advances by 1.
- XSTAT:
  - gp_wdata={0,old status}, gp_we=1.
  - status[2:0]=src_reg[2:0].
  - status[3] is loaded from src_reg[3] only when T=1; otherwise T is unchanged.
  - PC advances by 1.
- Flag updates:
  - flag_we updates status[2:0] on the edge where it is sampled.
  - An XSTAT accepted on the same edge overrides the flag_we update.
  - T is never changed by flag_we.
- Trap sources, in priority order:
  1. alu_trap high in RUN. No instruction is accepted; epc=pc.
  2. Accepted TRAP: epc=pc+1.
  3. Accepted illegal opcode: epc=pc+1.
- Trap entry with T=0: pc=TRAP_VECTOR, T=1, state goes to TRAP_ENTER.
- Trap with T=1 (double fault): state goes to HALT, halted=1. pc, epc and status hold.
- RTT (see Configuration): pc=epc, T=0.
- TRAP_ENTER lasts exactly one cycle with instr_ready=0, then returns to RUN.
- HALT: instr_ready=0. alu_trap and flag_we are ignored. Only reset leaves HALT.
- Reset asserted mid-operation, including in TRAP_ENTER or HALT, restores all reset values on the next edge.

## Timing
- pc, status and epc update on the accept edge; new values are visible in the following cycle.
- gp_we and branch_taken are high for exactly the one cycle after the accept edge. Otherwise they are 0.
- gp_wdata holds its last value when gp_we=0.
- Trap latency:
  - Trap edge: pc = TRAP_VECTOR.
  - Next cycle: no accept (TRAP_ENTER).
  - First new accept: two edges after the trap edge.
- Back-to-back accepts every cycle are supported in RUN; throughput is one instruction per cycle.
- instr_ready has a combinational path from alu_trap only.

## Configuration
- PROGRAM_FLOW_RTT_EN
  - Defined: epc is registered and RTT executes as specified.
  - Undefined: opcode 8 is illegal and traps like 9–15; epc still records the trap return PC; no return path exists.

## Test plan
- Reset, then JMP rel_addr=0x00005 from pc=0 -> pc=0x00005, branch_taken pulses for 1 cycle.
- Wrap-around: JMP rel_addr=0xFFFFE from pc=0x00001 -> pc=0xFFFFF, then NOP -> pc=0x00000.
- Conditional branches:
  - flag_we with flag_in=3'b001, then JMPZ +0x10 -> taken; JMPS +0x10 -> not taken (pc+1).
  - JMPZS with Z=0, S=1 -> taken.
- TRAP at pc=0x00020 -> pc=0x00010, epc=0x00021, T=1, instr_ready=0 for one cycle.
  - With PROGRAM_FLOW_RTT_EN: RTT -> pc=0x00021, T=0.
- alu_trap in trap mode -> halted=1, instr_ready=0 for 10 cycles; reset -> pc=0, halted=0.
- XSTAT src_reg=0x0000F with T=0 -> gp_wdata=old status, status=4'b0111 (T unchanged). Concurrent flag_we is ignored.

Source files
------------

// File: rtl/program_flow_unit_if.sv
// rtl/program_flow_unit_if.sv - instruction stream, ALU flag/trap and PC/status bus of the program-flow unit
interface program_flow_unit_if #(
  parameter int ADDR_W = 20
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rel_addr;
  logic [ADDR_W-1:0] src_reg;
  logic              flag_we;
  logic [2:0]        flag_in;
  logic              alu_trap;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        status;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] gp_wdata;
  logic              gp_we;
  logic              branch_taken;
  logic              halted;

  modport master (
    output instr_valid, opcode, rel_addr, src_reg, flag_we, flag_in, alu_trap,
    input  instr_ready, pc, status, epc, gp_wdata, gp_we, branch_taken, halted
  );

  modport slave (
    input  instr_valid, opcode, rel_addr, src_reg, flag_we, flag_in, alu_trap,
    output instr_ready, pc, status, epc, gp_wdata, gp_we, branch_taken, halted
  );
endinterface

// File: rtl/program_flow_unit.sv
// rtl/program_flow_unit.sv - PC/status owner with branches, traps and double-fault halt
// Optional return-from-trap (RTT, opcode 8) enabled by defining PROGRAM_FLOW_RTT_EN.
module program_flow_unit #(
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 'h00010
) (
  input logic                clock,
  input logic                reset,
  program_flow_unit_if.slave bus
);
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JMPZ  = 4'd2;
  localparam logic [3:0] OP_JMPS  = 4'd3;
  localparam logic [3:0] OP_JMPZS = 4'd4;
  localparam logic [3:0] OP_LSTAT = 4'd5;
  localparam logic [3:0] OP_XSTAT = 4'd6;
  localparam logic [3:0] OP_TRAP  = 4'd7;
`ifdef PROGRAM_FLOW_RTT_EN
  localparam logic [3:0] OP_RTT   = 4'd8;
`endif

  typedef enum logic [1:0] {RUN, TRAP_ENTER, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, gp_wdata_q, gp_wdata_d;
  logic [3:0]        status_q, status_d;
  logic              gp_we_q, gp_we_d, branch_taken_q, branch_taken_d;

  logic              accept;
  logic              taken;
  logic              trap_req;
  logic              flags_ok;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] trap_ret;
  logic              unused_src;

  assign unused_src      = ^bus.src_reg[ADDR_W-1:4];
  assign bus.instr_ready = (state_q == RUN) & ~bus.alu_trap;
  assign accept          = bus.instr_valid & bus.instr_ready;
  assign pc_inc          = pc_q + ADDR_W'(1);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    epc_d          = epc_q;
    status_d       = status_q;
    gp_wdata_d     = gp_wdata_q;
    gp_we_d        = 1'b0;
    branch_taken_d = 1'b0;
    taken          = 1'b0;
    trap_req       = 1'b0;
    trap_ret       = pc_q;
    flags_ok       = bus.flag_we;

    case (state_q)
      HALT:       flags_ok = 1'b0;
      TRAP_ENTER: state_d  = RUN;
      default: begin
        if (bus.alu_trap) begin
          trap_req = 1'b1;
          trap_ret = pc_q;
        end else if (accept) begin
          pc_d = pc_inc;
          case (bus.opcode)
            OP_NOP:   ;
            OP_JMP:   taken = 1'b1;
            OP_JMPZ:  taken = status_q[0];
            OP_JMPS:  taken = status_q[1];
            OP_JMPZS: taken = status_q[0] | status_q[1];
            OP_LSTAT: begin
              gp_wdata_d = {{(ADDR_W-4){1'b0}}, status_q};
              gp_we_d    = 1'b1;
            end
            OP_XSTAT: begin
              gp_wdata_d    = {{(ADDR_W-4){1'b0}}, status_q};
              gp_we_d       = 1'b1;
              status_d[2:0] = bus.src_reg[2:0];
              // T can only be rewritten from inside trap mode
              if (status_q[3]) status_d[3] = bus.src_reg[3];
              flags_ok      = 1'b0;
            end
`ifdef PROGRAM_FLOW_RTT_EN
            OP_RTT: begin
              pc_d        = epc_q;
              status_d[3] = 1'b0;
            end
`endif
            OP_TRAP: begin
              trap_req = 1'b1;
              trap_ret = pc_inc;
            end
            default: begin
              trap_req = 1'b1;
              trap_ret = pc_inc;
            end
          endcase
          if (taken) begin
            pc_d           = pc_q + bus.rel_addr;
            branch_taken_d = 1'b1;
          end
        end
      end
    endcase

    if (trap_req) begin
      if (status_q[3]) begin
        // double fault freezes pc/epc/status exactly as they were
        state_d  = HALT;
        pc_d     = pc_q;
        flags_ok = 1'b0;
      end else begin
        state_d     = TRAP_ENTER;
        pc_d        = TRAP_VECTOR;
        epc_d       = trap_ret;
        status_d[3] = 1'b1;
      end
    end

    if (flags_ok) status_d[2:0] = bus.flag_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      epc_q          <= '0;
      status_q       <= '0;
      gp_wdata_q     <= '0;
      gp_we_q        <= 1'b0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      status_q       <= status_d;
      gp_wdata_q     <= gp_wdata_d;
      gp_we_q        <= gp_we_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.status       = status_q;
  assign bus.epc          = epc_q;
  assign bus.gp_wdata     = gp_wdata_q;
  assign bus.gp_we        = gp_we_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.halted       = (state_q == HALT);
endmodule
